// File: rtl/div32.sv
// ============================================================================
//  Module   : div32
//  Purpose  : Sequential unsigned restoring divider that resolves one quotient
//             bit per clock behind a start/done handshake.
//  Options  : DIV32_DBZ_FLAG_EN adds a registered divide-by-zero flag (dbz).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] qut,
    output logic [WIDTH-1:0] rmd,
    output logic             done
`ifdef DIV32_DBZ_FLAG_EN
    ,
    output logic             dbz
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last_iter = CW'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] qut_q,   qut_d;
    logic [WIDTH-1:0] rmd_q,   rmd_d;
    logic             done_q,  done_d;
`ifdef DIV32_DBZ_FLAG_EN
    logic             dbz_q,   dbz_d;
`endif

    // The partial remainder is always below the divisor (or, for a zero
    // divisor, equal to the dividend bits shifted in so far), so WIDTH bits
    // of storage suffice; only the shifted trial value needs the extra bit.
    logic [WIDTH:0]   w_r_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    always_comb begin
        w_r_shift  = {rem_q, dvd_q[WIDTH-1]};
        w_diff     = w_r_shift - {1'b0, dvs_q};
        w_rem_next = w_diff[WIDTH] ? w_r_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_dvd_next = {dvd_q[WIDTH-2:0], ~w_diff[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qut_d   = qut_q;
        rmd_d   = rmd_q;
        done_d  = done_q;
`ifdef DIV32_DBZ_FLAG_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            c_idle: begin
                if (start) begin
                    dvd_d   = src1;
                    dvs_d   = src2;
                    rem_d   = '0;
                    cnt_d   = '0;
`ifdef DIV32_DBZ_FLAG_EN
                    dbz_d   = 1'b0;
`endif
                    state_d = c_busy;
                end
            end
            c_busy: begin
                rem_d = w_rem_next;
                dvd_d = w_dvd_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == c_last_iter) begin
                    qut_d   = w_dvd_next;
                    rmd_d   = w_rem_next;
                    done_d  = 1'b1;
`ifdef DIV32_DBZ_FLAG_EN
                    dbz_d   = (dvs_q == '0);
`endif
                    state_d = c_done;
                end
            end
            c_done: begin
                done_d  = 1'b0;
                state_d = c_idle;
            end
            default: begin
                done_d  = 1'b0;
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_idle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qut_q   <= '0;
            rmd_q   <= '0;
            done_q  <= 1'b0;
`ifdef DIV32_DBZ_FLAG_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qut_q   <= qut_d;
            rmd_q   <= rmd_d;
            done_q  <= done_d;
`ifdef DIV32_DBZ_FLAG_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign qut  = qut_q;
    assign rmd  = rmd_q;
    assign done = done_q;
`ifdef DIV32_DBZ_FLAG_EN
    assign dbz  = dbz_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div32.sv
// ============================================================================
//  Module   : tb_div32
//  Purpose  : Scoreboard bench for div32: stimulus pushes expected results,
//             a negedge monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] qut;
    logic [31:0] rmd;
    logic        done;
`ifdef DIV32_DBZ_FLAG_EN
    logic        dbz;
`endif

    div32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src1  (src1),
        .src2  (src2),
        .qut   (qut),
        .rmd   (rmd),
        .done  (done)
`ifdef DIV32_DBZ_FLAG_EN
        ,
        .dbz   (dbz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compares each done pulse against the oldest expectation.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) chk("done_one_cycle", {31'd0, done}, 32'd0);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("qut", qut, e.q);
                chk("rmd", rmd, e.r);
                chk("latency", cyc, e.cyc);
`ifdef DIV32_DBZ_FLAG_EN
                chk("dbz", {31'd0, dbz}, {31'd0, e.z});
`endif
            end
        end
        prev_done = (done === 1'b1);
    end

    // Start on the next posedge; returns at the negedge after that edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        src1  = a;
        src2  = b;
        e.q   = eq;
        e.r   = er;
        e.z   = (b == 32'd0);
        e.cyc = cyc + 33;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full directed division; returns at the negedge where done is visible so
    // the next issue() lands on the earliest legal start edge.
    task automatic div_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er);
        issue(a, b, eq, er, 1'b1);
        repeat (32) @(negedge clk);
    endtask

    task automatic div_golden(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) div_run(a, b, 32'hFFFF_FFFF, a);
        else            div_run(a, b, a / b, a % b);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst   = 1'b1;
        start = 1'b0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(negedge clk);
        chk("reset_qut",  qut, 32'd0);
        chk("reset_rmd",  rmd, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        div_run(32'd29, 32'd4, 32'd7, 32'd1);
        div_run(32'd5, 32'd7, 32'd0, 32'd5);
        div_run(32'd0, 32'd13, 32'd0, 32'd0);
        div_run(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        div_run(32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);
        div_run(32'd31, 32'd0, 32'hFFFF_FFFF, 32'd31);

        // Second start and operand churn during BUSY must be ignored.
        issue(32'd100, 32'd9, 32'd11, 32'd1, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        src1  = 32'd50;
        src2  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        src1 = 32'h1234_5678;
        src2 = 32'd3;
        chk("hold_qut_busy", qut, 32'hFFFF_FFFF);
        chk("hold_rmd_busy", rmd, 32'd31);
        repeat (24) @(negedge clk);
        src1 = '0;
        src2 = '0;
        repeat (3) @(negedge clk);
        chk("hold_qut_idle", qut, 32'd11);
        chk("hold_rmd_idle", rmd, 32'd1);

        // Reset mid-operation discards the division.
        issue(32'd100, 32'd9, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_qut",  qut, 32'd0);
        chk("midrst_rmd",  rmd, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (40) @(negedge clk);
        chk("midrst_quiet_qut", qut, 32'd0);
        div_run(32'd100, 32'd9, 32'd11, 32'd1);

        for (int i = 0; i < 250; i++) begin
            a = $urandom_range(31, 0);
            b = $urandom_range(31, 1);
            div_golden(a, b);
        end
        for (int i = 0; i < 250; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            div_golden(a, b);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
